// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with optional skid entry, flush-pending kill and bubble counter
module pipe_stage_buf #(
    parameter int PC_W      = 32,
    parameter int INST_W    = 32,
    parameter int EXC_W     = 32,
    parameter int SKID      = 1,
    parameter int KILL_PEND = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [EXC_W-1:0]  out_exc,
    output logic              flush_pend_o,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              m_valid, s_valid, flush_pend;
    logic [PC_W-1:0]   s_pc;
    logic [INST_W-1:0] s_inst;
    logic [EXC_W-1:0]  s_exc;
    logic              accept, drain, take;

    // handshake events; a pending kill swallows the next accepted entry
    always_comb begin
        in_ready = (SKID != 0) ? !s_valid : (!m_valid | out_ready);
        accept   = in_valid & in_ready;
        drain    = m_valid & out_ready;
        take     = accept & !((KILL_PEND != 0) & flush_pend);
    end

    assign out_valid    = m_valid;
    assign flush_pend_o = flush_pend;

    // main/skid storage; payload is kept zero whenever its entry is invalid
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_valid  <= 1'b0;
            out_pc   <= '0;
            out_inst <= '0;
            out_exc  <= '0;
            s_valid  <= 1'b0;
            s_pc     <= '0;
            s_inst   <= '0;
            s_exc    <= '0;
        end else if (SKID != 0) begin
            if (drain && s_valid) begin
                m_valid  <= 1'b1;
                out_pc   <= s_pc;
                out_inst <= s_inst;
                out_exc  <= s_exc;
                s_valid  <= 1'b0;
                s_pc     <= '0;
                s_inst   <= '0;
                s_exc    <= '0;
            end else if (drain) begin
                m_valid  <= take;
                out_pc   <= take ? in_pc : '0;
                out_inst <= take ? in_inst : '0;
                out_exc  <= take ? in_exc : '0;
            end else if (take && m_valid) begin
                s_valid <= 1'b1;
                s_pc    <= in_pc;
                s_inst  <= in_inst;
                s_exc   <= in_exc;
            end else if (take) begin
                m_valid  <= 1'b1;
                out_pc   <= in_pc;
                out_inst <= in_inst;
                out_exc  <= in_exc;
            end
        end else if (take || drain) begin
            m_valid  <= take;
            out_pc   <= take ? in_pc : '0;
            out_inst <= take ? in_inst : '0;
            out_exc  <= take ? in_exc : '0;
        end
    end

    // kill tracker: a flush without an accept leaves the wrong-path fetch still to come
    always_ff @(posedge clk) begin
        if (rst || KILL_PEND == 0)
            flush_pend <= 1'b0;
        else if (flush)
            flush_pend <= !accept;
        else if (accept)
            flush_pend <= 1'b0;
    end

    // saturating count of cycles with no valid output
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            bubble_cnt <= '0;
        else if (!m_valid && bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of the skid build and a single-register build
module tb_pipe_stage_buf;
    logic        clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 1, cnt_clr = 0;
    logic [31:0] in_pc = 0, in_inst = 0, in_exc = 0;
    logic        in_ready, out_valid, flush_pend_o;
    logic [31:0] out_pc, out_inst, out_exc;
    logic [3:0]  bubble_cnt;
    logic        z_in_ready, z_out_valid, z_flush_pend_o;
    logic [31:0] z_out_pc, z_out_inst, z_out_exc;
    logic [3:0]  z_bubble_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_exc(out_exc), .flush_pend_o(flush_pend_o),
        .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_buf #(.SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc), .flush(flush),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_pc(z_out_pc),
        .out_inst(z_out_inst), .out_exc(z_out_exc), .flush_pend_o(z_flush_pend_o),
        .cnt_clr(cnt_clr), .bubble_cnt(z_bubble_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] exc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = pc ^ 32'hA5A5_0000;
        in_exc   = exc;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(0, 0, 0);
        step();
        step();
        rst = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        checks++; if (bubble_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        checks++; if (flush_pend_o !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", flush_pend_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3] = '{32'h100, 32'h104, 32'h108};
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, exp_pc[i], 0);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%b exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin failures++; $display("FAIL stream_out%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, exp_pc[i]); end
            checks++; if (out_inst !== (exp_pc[i] ^ 32'hA5A5_0000)) begin failures++; $display("FAIL stream_inst%0d got=%h exp=%h", i, out_inst, exp_pc[i] ^ 32'hA5A5_0000); end
        end
        drive(0, 0, 0);
        step();
        checks++; if (bubble_cnt !== 4'd2) begin failures++; $display("FAIL stream_cnt got=%0d exp=2", bubble_cnt); end
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL stream_empty got=%b/%h exp=0/0", out_valid, out_pc); end
    endtask

    task automatic test_skid();
        out_ready = 0;
        drive(1, 32'h200, 0);
        step();
        checks++; if (out_pc !== 32'h200 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_m got=%h/%b exp=200/1", out_pc, in_ready); end
        drive(1, 32'h204, 0);
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_full got=%b exp=0", in_ready); end
        drive(1, 32'h208, 0);
        step();
        checks++; if (out_pc !== 32'h200 || in_ready !== 1'b0) begin failures++; $display("FAIL skid_hold got=%h/%b exp=200/0", out_pc, in_ready); end
        out_ready = 1;
        step();
        checks++; if (out_pc !== 32'h204 || out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_d1 got=%h/%b/%b exp=204/1/1", out_pc, out_valid, in_ready); end
        step();
        checks++; if (out_pc !== 32'h208 || out_valid !== 1'b1) begin failures++; $display("FAIL skid_d2 got=%h/%b exp=208/1", out_pc, out_valid); end
        drive(0, 0, 0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_nodup got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush_held();
        out_ready = 0;
        drive(1, 32'h300, 32'h3);
        step();
        drive(1, 32'h304, 32'h4);
        step();
        checks++; if (out_pc !== 32'h300 || out_exc !== 32'h3 || in_ready !== 1'b0) begin failures++; $display("FAIL fh_load got=%h/%h/%b exp=300/3/0", out_pc, out_exc, in_ready); end
        drive(0, 0, 0);
        flush = 1;
        step();
        flush = 0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || flush_pend_o !== 1'b1) begin failures++; $display("FAIL fh_flush got=%b/%h/%b exp=0/0/1", out_valid, out_pc, flush_pend_o); end
        drive(1, 32'h308, 0);
        step();
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || flush_pend_o !== 1'b0) begin failures++; $display("FAIL fh_kill got=%b/%h/%b exp=0/0/0", out_valid, out_pc, flush_pend_o); end
        drive(1, 32'h30C, 0);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h30C) begin failures++; $display("FAIL fh_next got=%b/%h exp=1/30c", out_valid, out_pc); end
        out_ready = 1;
        drive(0, 0, 0);
        step();
        flush = 1;
        step();
        step();
        flush = 0;
        checks++; if (flush_pend_o !== 1'b1) begin failures++; $display("FAIL fh_repeat got=%b exp=1", flush_pend_o); end
    endtask

    task automatic test_flush_accept();
        drive(1, 32'h400, 0);
        flush = 1;
        step();
        flush = 0;
        checks++; if (out_valid !== 1'b0 || flush_pend_o !== 1'b0) begin failures++; $display("FAIL fa_drop got=%b/%b exp=0/0", out_valid, flush_pend_o); end
        drive(1, 32'h404, 0);
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h404) begin failures++; $display("FAIL fa_next got=%b/%h exp=1/404", out_valid, out_pc); end
        drive(0, 0, 0);
        step();
    endtask

    task automatic test_exception();
        drive(1, 32'h500, 32'h10);
        step();
        checks++; if (out_exc !== 32'h10 || out_pc !== 32'h500) begin failures++; $display("FAIL exc_pass got=%h/%h exp=10/500", out_exc, out_pc); end
        drive(0, 0, 0);
        step();
        out_ready = 0;
        drive(1, 32'h504, 32'h10);
        step();
        checks++; if (out_exc !== 32'h10) begin failures++; $display("FAIL exc_held got=%h exp=10", out_exc); end
        drive(0, 0, 0);
        flush = 1;
        step();
        flush = 0;
        checks++; if (out_exc !== 32'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL exc_flush got=%h/%b exp=0/0", out_exc, out_valid); end
        drive(1, 32'h508, 32'h20);
        step();
        checks++; if (out_valid !== 1'b0 || out_exc !== 32'h0 || flush_pend_o !== 1'b0) begin failures++; $display("FAIL exc_kill got=%b/%h/%b exp=0/0/0", out_valid, out_exc, flush_pend_o); end
        drive(0, 0, 0);
        out_ready = 1;
    endtask

    task automatic test_counter();
        for (int i = 0; i < 20; i++) step();
        checks++; if (bubble_cnt !== 4'd15) begin failures++; $display("FAIL cnt_sat got=%0d exp=15", bubble_cnt); end
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        checks++; if (bubble_cnt !== 4'd0) begin failures++; $display("FAIL cnt_clr got=%0d exp=0", bubble_cnt); end
        step();
        checks++; if (bubble_cnt !== 4'd1) begin failures++; $display("FAIL cnt_inc got=%0d exp=1", bubble_cnt); end
    endtask

    task automatic test_single_reg();
        out_ready = 0;
        drive(1, 32'h600, 0);
        step();
        checks++; if (z_out_valid !== 1'b1 || z_out_pc !== 32'h600 || z_in_ready !== 1'b0) begin failures++; $display("FAIL s0_hold got=%b/%h/%b exp=1/600/0", z_out_valid, z_out_pc, z_in_ready); end
        out_ready = 1;
        #1;
        checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL s0_comb got=%b exp=1", z_in_ready); end
        drive(1, 32'h604, 0);
        step();
        checks++; if (z_out_pc !== 32'h604 || z_out_valid !== 1'b1) begin failures++; $display("FAIL s0_tp1 got=%h/%b exp=604/1", z_out_pc, z_out_valid); end
        drive(1, 32'h608, 0);
        step();
        checks++; if (z_out_pc !== 32'h608 || z_out_valid !== 1'b1) begin failures++; $display("FAIL s0_tp2 got=%h/%b exp=608/1", z_out_pc, z_out_valid); end
        drive(0, 0, 0);
        step();
        checks++; if (z_out_valid !== 1'b0 || z_out_pc !== 32'h0) begin failures++; $display("FAIL s0_empty got=%b/%h exp=0/0", z_out_valid, z_out_pc); end
    endtask

    task automatic test_mid_reset();
        out_ready = 0;
        drive(1, 32'h700, 0);
        step();
        drive(0, 0, 0);
        rst = 1;
        step();
        rst = 0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid got=%b/%h/%b exp=0/0/1", out_valid, out_pc, in_ready); end
        out_ready = 1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush_held();
        test_flush_accept();
        test_exception();
        test_counter();
        test_single_reg();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-width IF/EX pipeline register.
- Carries {pc, inst, exception} between two pipeline stages over a valid/ready handshake, with an optional second-entry skid buffer so that back-pressure does not lose fetched instructions.
- Adds a flush-pending tracker that kills one in-flight wrong-path instruction, plus a saturating bubble counter for performance monitoring.
- Sits between fetch and execute; it is reusable between any two stages.

Parameters:
PC_W, 32, program-counter width
INST_W, 32, instruction width
EXC_W, 32, exception-vector width
SKID, 1, 0 = single register stage; 1 = two-entry skid buffer (main M + skid S)
KILL_PEND, 1, 1 = enable the flush-pending kill of the next accepted input; 0 = flush clears storage only
CNT_W, 16, bubble-counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream offers an entry
in_ready  out  1  block can accept an entry this cycle
in_pc  in  PC_W  upstream pc
in_inst  in  INST_W  upstream instruction
in_exc  in  EXC_W  upstream exception bits
flush  in  1  kill all held and in-flight entries
out_valid  out  1  M holds a valid entry
out_ready  in  1  downstream consumes M this cycle
out_pc  out  PC_W  M pc
out_inst  out  INST_W  M instruction
out_exc  out  EXC_W  M exception bits
flush_pend_o  out  1  a kill is pending for the next accepted input
cnt_clr  in  1  clear the bubble counter
bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rst=1 clears M_valid, S_valid and flush_pend. It zeroes out_pc, out_inst, out_exc, all S payload and bubble_cnt. Reset mid-operation discards all held entries. in_ready is 1 in the first cycle after reset.
- Events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- in_ready:
  - SKID=1: in_ready = !S_valid. It is purely register-derived, with no combinational path from out_ready.
  - SKID=0: in_ready = !M_valid | out_ready.
- Latency: an entry accepted in cycle N appears on out_* with out_valid=1 in cycle N+1.
- Ordering: entries leave in acceptance order. S is never valid while M is empty.
- Normal update when flush=0 (SKID=1):
  - accept and (!M_valid or drain) and !S_valid: M <= in.
  - accept and M_valid and !drain: S <= in.
  - drain and S_valid: M <= S and S_valid <= 0. in_ready returns to 1 the following cycle.
  - drain and !S_valid and !accept: M_valid <= 0 and M payload zeroed. Payload is zero whenever the entry is invalid.
- Flush (highest priority after rst):
  - M_valid and S_valid are cleared and all payloads zeroed the next cycle.
  - Any entry accepted in the flush cycle is discarded.
  - A drain coincident with flush still completes; downstream has sampled it.
- flush_pend (KILL_PEND=1):
  - Set on a flush cycle with no accept.
  - Cleared on a flush cycle with an accept; that entry is the wrong-path instruction and has been discarded.
  - While flush_pend=1 and flush=0, the next accepted entry is dropped (not stored) and flush_pend clears in the same edge.
  - Repeated flushes keep it set.
- flush_pend (KILL_PEND=0): flush_pend_o is tied to 0.
- Dropped or killed entries never assert out_valid.
- bubble_cnt:
  - Increments each cycle with rst=0 and out_valid=0.
  - Holds at 2^CNT_W-1 (saturation).
  - cnt_clr=1 zeroes it, taking priority over increment.
- Exceptions: in_exc travels with its entry unchanged. It is zeroed on flush or kill exactly like pc and inst.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then 3 back-to-back accepts pc=0x100/0x104/0x108 with out_ready=1 -> out_valid from cycle after first accept, out_pc 0x100,0x104,0x108 in consecutive cycles; in_ready constant 1; bubble_cnt=2 (two post-reset empty cycles) then holds.
- Back-pressure skid (SKID=1): out_ready=0, accept 0x200 then 0x204 -> M=0x200, S=0x204, in_ready=0 next cycle; in_valid held with 0x208 is not accepted; raise out_ready -> 0x200, 0x204, 0x208 delivered in order, none lost or duplicated.
- Flush with held data: M=0x300, S=0x304, flush=1 and in_valid=0 -> next cycle out_valid=0, out_pc=0, flush_pend_o=1; next accept 0x308 is dropped and flush_pend_o=0; the following accept 0x30C appears on out_pc.
- Flush coincident with accept: flush=1 and accept 0x400 in the same cycle -> 0x400 never appears, flush_pend_o=0, next accept 0x404 delivered normally.
- Exception propagation and kill: accept in_exc=0x0000_0010 at pc 0x500 -> out_exc=0x10 with pc 0x500. Repeat with flush in the next cycle and out_ready=0 -> out_exc=0 after the flush.
- Counter and mode checks: CNT_W=4 with idle input for 20 cycles -> bubble_cnt saturates at 15; cnt_clr=1 -> 0 next cycle. SKID=0 build: out_ready=0 with M valid -> in_ready=0 combinationally; out_ready=1 -> simultaneous drain and accept gives throughput of 1 per cycle.
